alarm_zones: RTL and testbench



---
 rtl/alarm_zones_if.sv | 26 ++
 rtl/alarm_zones.sv | 193 +++++++++++++++++++
 tb/tb_alarm_zones.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_zones_if.sv
// alarm_zones_if: groups the sensor inputs and the alarm/status outputs of
// alarm_zones into one bundle. The master side drives the arm request and
// the sensors. The slave side (the alarm core) drives the status outputs.
interface alarm_zones_if #(
    parameter int ZONES = 4
);
    logic             A;
    logic [ZONES-1:0] V;
    logic [ZONES-1:0] M;
    logic             L;
    logic             armed;
    logic             entry_warn;
    logic [2:0]       state;
    logic [ZONES-1:0] tripped;
    logic             chime;

    modport master (
        output A, V, M,
        input  L, armed, entry_warn, state, tripped, chime
    );

    modport slave (
        input  A, V, M,
        output L, armed, entry_warn, state, tripped, chime
    );
endinterface

// File: rtl/alarm_zones.sv
// alarm_zones: multi-zone intruder alarm controller.
//
// Each zone trips when its door/window sensor opens or its motion sensor fires.
// Zone 0 is the delayed entry zone. All other zones alarm instantly.
// The state machine provides the following timing:
//   - an exit delay after arming,
//   - an entry delay on zone 0,
//   - a bounded siren time with automatic re-arm.
// Zones that trip while the system is armed are recorded in a sticky
// "tripped" register. The user can read this register after disarming.
//
// Optional feature: define ALARM_CHIME_EN to get a one-cycle door chime.
// The chime fires when any zone starts tripping while the system is disarmed.
// Without the macro, chime is tied to 0.
module alarm_zones #(
    parameter int ZONES      = 4,
    parameter int EXIT_DLY   = 8,
    parameter int ENTRY_DLY  = 8,
    parameter int SIREN_TIME = 16
) (
    input  logic          clk,
    input  logic          reset,
    alarm_zones_if.slave  bus
);

    localparam int MAX_A = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
    localparam int MAX_D = (MAX_A > SIREN_TIME) ? MAX_A : SIREN_TIME;
    localparam int CW    = $clog2(MAX_D + 1);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_EXIT  = 3'd1,
        S_ARMED = 3'd2,
        S_ENTRY = 3'd3,
        S_ALARM = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_nextCnt;
    logic             r_L;
    logic [ZONES-1:0] r_tripped;
    logic [ZONES-1:0] w_trip;
    logic             w_ent;
    logic             w_inst;
    logic             w_armed;
    logic             w_entryWarn;

    // A zone trips when its contact opens or its motion sensor fires.
    assign w_trip = ~bus.V | bus.M;
    assign w_ent  = w_trip[0];

    // The instant-zone OR only exists when there is more than one zone.
    generate
        if (ZONES > 1) begin : g_inst
            assign w_inst = |w_trip[ZONES-1:1];
        end else begin : g_noInst
            assign w_inst = 1'b0;
        end
    endgenerate

    // State register and the shared delay counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Next-state logic. Disarming overrides everything, including a running siren.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        if (!bus.A) begin
            w_nextState = S_OFF;
            w_nextCnt   = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_nextState = S_EXIT;
                    w_nextCnt   = CW'(EXIT_DLY - 1);
                end
                S_EXIT: begin
                    if (r_cnt == '0) begin
                        w_nextState = S_ARMED;
                    end else begin
                        w_nextCnt = r_cnt - 1'b1;
                    end
                end
                S_ARMED: begin
                    if (w_inst) begin
                        w_nextState = S_ALARM;
                        w_nextCnt   = CW'(SIREN_TIME - 1);
                    end else if (w_ent) begin
                        w_nextState = S_ENTRY;
                        w_nextCnt   = CW'(ENTRY_DLY - 1);
                    end
                end
                S_ENTRY: begin
                    if (w_inst || r_cnt == '0) begin
                        w_nextState = S_ALARM;
                        w_nextCnt   = CW'(SIREN_TIME - 1);
                    end else begin
                        w_nextCnt = r_cnt - 1'b1;
                    end
                end
                S_ALARM: begin
                    if (r_cnt == '0) begin
                        w_nextState = S_ARMED;
                    end else begin
                        w_nextCnt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_nextState = S_OFF;
                    w_nextCnt   = '0;
                end
            endcase
        end
    end

    // Status outputs are decoded from the state register only.
    // This keeps them free of any input-to-output path.
    always_comb begin
        w_armed     = 1'b0;
        w_entryWarn = 1'b0;
        case (r_state)
            S_ARMED: w_armed = 1'b1;
            S_ENTRY: begin
                w_armed     = 1'b1;
                w_entryWarn = 1'b1;
            end
            S_ALARM: w_armed = 1'b1;
            default: begin
                w_armed     = 1'b0;
                w_entryWarn = 1'b0;
            end
        endcase
    end

    // The siren output is registered alongside the state.
    // It is high exactly while the state is ALARM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_L <= 1'b0;
        end else begin
            r_L <= (w_nextState == S_ALARM);
        end
    end

    // Sticky record of offending zones. It is cleared only when a new arming
    // cycle starts, so it survives disarming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tripped <= '0;
        end else if (r_state == S_OFF && bus.A) begin
            r_tripped <= '0;
        end else if (r_state == S_ARMED || r_state == S_ENTRY || r_state == S_ALARM) begin
            r_tripped <= r_tripped | w_trip;
        end
    end

`ifdef ALARM_CHIME_EN
    logic r_prevAny;
    logic r_chime;

    // Door chime: pulse once when any zone starts tripping while disarmed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prevAny <= 1'b0;
            r_chime   <= 1'b0;
        end else begin
            r_prevAny <= |w_trip;
            r_chime   <= (r_state == S_OFF) && (|w_trip) && !r_prevAny;
        end
    end

    assign bus.chime = r_chime;
`else
    assign bus.chime = 1'b0;
`endif

    assign bus.L          = r_L;
    assign bus.armed      = w_armed;
    assign bus.entry_warn = w_entryWarn;
    assign bus.state      = r_state;
    assign bus.tripped    = r_tripped;

endmodule

// File: tb/tb_alarm_zones.sv
// tb_alarm_zones: scoreboard bench for alarm_zones.
// Stimulus drives inputs on the falling edge. For every cycle it pushes the
// outputs a phase/elapsed-time reference model expects after the next
// rising edge. A monitor samples the DUT just after each rising edge and
// compares the sample against the queued expectation.
module tb_alarm_zones;

    localparam int ZONES      = 4;
    localparam int EXIT_DLY   = 4;
    localparam int ENTRY_DLY  = 3;
    localparam int SIREN_TIME = 5;

    typedef struct packed {
        logic [2:0] st;
        logic       l;
        logic       arm;
        logic       ew;
        logic [3:0] tr;
        logic       ch;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   passes;
    exp_t sbQ[$];

    // Reference model: phase number plus cycles spent in the current timed phase.
    int       mPhase;
    int       mElapsed;
    bit [3:0] mTripped;
    bit       mPrevAny;
    bit       mChime;

    alarm_zones_if #(.ZONES(ZONES)) bus();

    alarm_zones #(
        .ZONES(ZONES),
        .EXIT_DLY(EXIT_DLY),
        .ENTRY_DLY(ENTRY_DLY),
        .SIREN_TIME(SIREN_TIME)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock with a 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached (act=running, req=finished)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compares one field and counts the result.
    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Resets the reference model to the power-on state.
    task automatic modelReset();
        mPhase   = 0;
        mElapsed = 0;
        mTripped = '0;
        mPrevAny = 1'b0;
        mChime   = 1'b0;
    endtask

    // Advances the reference model by one rising edge.
    task automatic modelStep(input bit a, input bit [3:0] v, input bit [3:0] m);
        bit [3:0] trip;
        bit       ent;
        bit       inst;
        trip = ~v | m;
        ent  = trip[0];
        inst = |trip[3:1];
        if (mPhase >= 2) mTripped = mTripped | trip;
        if (mPhase == 0 && a) mTripped = '0;
`ifdef ALARM_CHIME_EN
        mChime = (mPhase == 0) && (trip != 0) && !mPrevAny;
`else
        mChime = 1'b0;
`endif
        mPrevAny = (trip != 0);
        if (!a) begin
            mPhase = 0;
        end else if (mPhase == 0) begin
            mPhase = 1;
            mElapsed = 1;
        end else if (mPhase == 1) begin
            if (mElapsed == EXIT_DLY) mPhase = 2;
            else mElapsed++;
        end else if (mPhase == 2) begin
            if (inst) begin
                mPhase = 4;
                mElapsed = 1;
            end else if (ent) begin
                mPhase = 3;
                mElapsed = 1;
            end
        end else if (mPhase == 3) begin
            if (inst || mElapsed == ENTRY_DLY) begin
                mPhase = 4;
                mElapsed = 1;
            end else begin
                mElapsed++;
            end
        end else begin
            if (mElapsed == SIREN_TIME) mPhase = 2;
            else mElapsed++;
        end
    endtask

    // Drives one cycle of inputs and queues the expected outputs after the next edge.
    task automatic applyStimulus(input bit a, input bit [3:0] v, input bit [3:0] m);
        exp_t e;
        @(negedge clk);
        bus.A = a;
        bus.V = v;
        bus.M = m;
        modelStep(a, v, m);
        e.st  = 3'(mPhase);
        e.l   = (mPhase == 4);
        e.arm = (mPhase >= 2);
        e.ew  = (mPhase == 3);
        e.tr  = mTripped;
        e.ch  = mChime;
        sbQ.push_back(e);
    endtask

    // Checks that every output is at its reset value.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_state"}, 8'(bus.state), 8'd0);
        checkOutput({tag, "_L"}, 8'(bus.L), 8'd0);
        checkOutput({tag, "_armed"}, 8'(bus.armed), 8'd0);
        checkOutput({tag, "_entry_warn"}, 8'(bus.entry_warn), 8'd0);
        checkOutput({tag, "_tripped"}, 8'(bus.tripped), 8'd0);
        checkOutput({tag, "_chime"}, 8'(bus.chime), 8'd0);
    endtask

    // Asserts reset between edges and expects the outputs to clear without a clock.
    task automatic asyncResetCheck();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkResetOutputs("async_reset");
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    // Monitor: pops one expectation per rising edge when one is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput("state", 8'(bus.state), 8'(e.st));
                checkOutput("L", 8'(bus.L), 8'(e.l));
                checkOutput("armed", 8'(bus.armed), 8'(e.arm));
                checkOutput("entry_warn", 8'(bus.entry_warn), 8'(e.ew));
                checkOutput("tripped", 8'(bus.tripped), 8'(e.tr));
                checkOutput("chime", 8'(bus.chime), 8'(e.ch));
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        bit       a;
        bit [3:0] v;
        bit [3:0] m;
        checks = 0;
        passes = 0;
        reset  = 1'b1;
        bus.A  = 1'b0;
        bus.V  = 4'hF;
        bus.M  = 4'h0;
        modelReset();
        #2;
        checkResetOutputs("power_on_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle, then arm with every motion sensor firing during the exit delay.
        applyStimulus(0, 4'hF, 4'h0);
        applyStimulus(1, 4'hF, 4'hF);
        applyStimulus(1, 4'hF, 4'hF);
        applyStimulus(1, 4'hF, 4'hF);
        applyStimulus(1, 4'hF, 4'h0);
        applyStimulus(1, 4'hF, 4'h0);
        applyStimulus(1, 4'hF, 4'h0);

        // Instant zone: one-cycle motion on zone 2, then the siren runs out and the system re-arms.
        applyStimulus(1, 4'hF, 4'h4);
        repeat (6) applyStimulus(1, 4'hF, 4'h0);

        // Fresh arming, then entry delay through to the alarm.
        applyStimulus(0, 4'hF, 4'h0);
        repeat (5) applyStimulus(1, 4'hF, 4'h0);
        applyStimulus(1, 4'hE, 4'h0);
        repeat (9) applyStimulus(1, 4'hF, 4'h0);

        // Fresh arming, then disarm during the entry delay.
        applyStimulus(0, 4'hF, 4'h0);
        repeat (5) applyStimulus(1, 4'hF, 4'h0);
        applyStimulus(1, 4'hE, 4'h0);
        applyStimulus(1, 4'hF, 4'h0);
        applyStimulus(0, 4'hF, 4'h0);
        applyStimulus(0, 4'hF, 4'h0);

        // Simultaneous entry and instant trips, then escalation from entry.
        repeat (5) applyStimulus(1, 4'hF, 4'h0);
        applyStimulus(1, 4'hE, 4'h2);
        repeat (5) applyStimulus(1, 4'hF, 4'h0);
        applyStimulus(1, 4'hE, 4'h0);
        applyStimulus(1, 4'hF, 4'h8);
        repeat (2) applyStimulus(1, 4'hF, 4'h0);

        // Asynchronous reset in the middle of an alarm.
        asyncResetCheck();

        // Door opening while disarmed and held open.
        applyStimulus(0, 4'hF, 4'h0);
        applyStimulus(0, 4'hD, 4'h0);
        repeat (3) applyStimulus(0, 4'hD, 4'h0);
        applyStimulus(0, 4'hF, 4'h0);

        // Randomized traffic: mostly armed, with sparse sensor activity.
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 24) != 0);
            for (int z = 0; z < ZONES; z++) begin
                v[z] = ($urandom_range(0, 7) != 0);
                m[z] = ($urandom_range(0, 11) == 0);
            end
            applyStimulus(a, v, m);
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sbQ.size() > 0; k++) @(posedge clk);
        #2;
        checks++;
        if (sbQ.size() == 0) begin
            passes++;
        end else begin
            $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", sbQ.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
